// File: rtl/quad_decoder_if.sv
// Encoder-side signal bundle for quad_decoder: raw A/B phases and clears in,
// step/dir/pos/err out.
interface quad_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a_in;
  logic             b_in;
  logic             clr;
  logic             err_clr;
  logic             step;
  logic             dir;
  logic [WIDTH-1:0] pos;
  logic             err;

  modport master (
    output a_in, b_in, clr, err_clr,
    input  step, dir, pos, err
  );

  modport slave (
    input  a_in, b_in, clr, err_clr,
    output step, dir, pos, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and deglitches A/B, then turns each legal
// Gray-code transition into a one-cycle step pulse with direction and a wrapping position.
module quad_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic           clk,
  input  logic           rst,
  quad_decoder_if.slave  bus
);

  localparam int unsigned FcntW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ArmW    = $clog2(SYNC_STAGES + FILTER_LEN + 2);
  localparam logic [FcntW-1:0] FcntMax = FcntW'(FILTER_LEN - 1);
  localparam logic [ArmW-1:0]  ArmInit = ArmW'(SYNC_STAGES + FILTER_LEN + 1);

  // Channel index 1 is phase A, index 0 is phase B, so {filt[1], filt[0]} = {A, B}.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [1:0]             synced;
  logic [1:0]             filt_q, filt_d;
  logic [FcntW-1:0]       fcnt_q [2];
  logic [FcntW-1:0]       fcnt_d [2];

  logic [1:0]       prev_q;
  logic [ArmW-1:0]  arm_q, arm_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             err_q, err_d;

  logic fwd, bwd, illegal, armed;

  assign raw    = {bus.a_in, bus.b_in};
  assign synced = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  // A new level must persist FILTER_LEN consecutive edges before it is accepted.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (synced[i] != filt_q[i]) begin
        if (fcnt_q[i] == FcntMax) begin
          filt_d[i] = synced[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FcntW'(1);
        end
      end
    end
  end

  always_comb begin
    fwd = 1'b0;
    bwd = 1'b0;
    case ({prev_q, filt_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: bwd = 1'b1;
      default: ;
    endcase
  end

  assign illegal = ((prev_q ^ filt_q) == 2'b11);
  assign armed   = (arm_q == '0);

  always_comb begin
    arm_d  = armed ? arm_q : arm_q - ArmW'(1);
    step_d = armed & (fwd | bwd);
    dir_d  = step_d ? fwd : dir_q;

    pos_d = pos_q;
    if (bus.clr) begin
      pos_d = '0;
    end else if (step_d) begin
      pos_d = fwd ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
    end

    // An accepted illegal transition wins over a simultaneous err_clr.
    err_d = err_q;
    if (armed && illegal) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        fcnt_q[i] <= '0;
      end
      filt_q <= '0;
      prev_q <= '0;
      arm_q  <= ArmInit;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      pos_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        fcnt_q[i] <= fcnt_d[i];
      end
      filt_q <= filt_d;
      prev_q <= filt_q;
      arm_q  <= arm_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
      err_q  <= err_d;
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.pos  = pos_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: arming, counting, wrap, glitch rejection,
// illegal transitions and clear/reset collisions.
module tb_quad_decoder;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulse_cnt = 0;
  int   p0;
  logic [1:0]       ab;
  logic [WIDTH-1:0] epos;

  quad_decoder_if #(.WIDTH(WIDTH)) bus ();

  quad_decoder #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2),
    .FILTER_LEN (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.step === 1'b1) pulse_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] up(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] down(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Apply one legal edge and hold it 8 clocks; the pulse must land exactly 6 edges later.
  task automatic move(input logic [1:0] s, input logic exp_dir, input logic [WIDTH-1:0] exp_pos,
                      input string tag);
    {bus.a_in, bus.b_in} = s;
    tick(5);
    check({tag, " step_early"}, 32'(bus.step), 32'd0);
    tick(1);
    check({tag, " step"}, 32'(bus.step), 32'd1);
    check({tag, " dir"}, 32'(bus.dir), 32'(exp_dir));
    check({tag, " pos"}, 32'(bus.pos), 32'(exp_pos));
    tick(1);
    check({tag, " step_width"}, 32'(bus.step), 32'd0);
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    bus.clr = 1'b0;
    bus.err_clr = 1'b0;

    // Reset with encoder resting at 11
    tick(3);
    check("rst step", 32'(bus.step), 32'd0);
    check("rst dir", 32'(bus.dir), 32'd0);
    check("rst pos", 32'(bus.pos), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    p0 = pulse_cnt;
    tick(10);
    check("arm pulses", 32'(pulse_cnt - p0), 32'd0);
    check("arm err", 32'(bus.err), 32'd0);
    check("arm pos", 32'(bus.pos), 32'd0);

    // Restart from 00
    rst = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("arm00 pos", 32'(bus.pos), 32'd0);

    // Forward then backward, 16 edges each
    ab = 2'b00;
    epos = '0;
    p0 = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      ab = up(ab);
      epos = epos + 8'd1;
      move(ab, 1'b1, epos, $sformatf("up%0d", i));
    end
    check("up pulses", 32'(pulse_cnt - p0), 32'd16);
    check("up pos16", 32'(bus.pos), 32'd16);
    for (int i = 0; i < 16; i++) begin
      ab = down(ab);
      epos = epos - 8'd1;
      move(ab, 1'b0, epos, $sformatf("dn%0d", i));
    end
    check("dn pos0", 32'(bus.pos), 32'd0);
    check("dn dir", 32'(bus.dir), 32'd0);

    // Wrap below zero and back
    ab = down(ab);
    move(ab, 1'b0, 8'd255, "wrap_dn");
    ab = up(ab);
    move(ab, 1'b1, 8'd0, "wrap_up");

    // 2-cycle glitch on A is rejected
    p0 = pulse_cnt;
    bus.a_in = 1'b1;
    tick(2);
    bus.a_in = 1'b0;
    tick(10);
    check("glitch2 pulses", 32'(pulse_cnt - p0), 32'd0);
    check("glitch2 err", 32'(bus.err), 32'd0);
    check("glitch2 pos", 32'(bus.pos), 32'd0);

    // 3-cycle pulse on A: 00->10 is a down edge, 10->00 an up edge
    bus.a_in = 1'b1;
    tick(3);
    bus.a_in = 1'b0;
    tick(3);
    check("pulse3 rise step", 32'(bus.step), 32'd1);
    check("pulse3 rise dir", 32'(bus.dir), 32'd0);
    check("pulse3 rise pos", 32'(bus.pos), 32'd255);
    tick(3);
    check("pulse3 fall step", 32'(bus.step), 32'd1);
    check("pulse3 fall dir", 32'(bus.dir), 32'd1);
    check("pulse3 fall pos", 32'(bus.pos), 32'd0);
    tick(5);
    check("pulse3 pulses", 32'(pulse_cnt - p0), 32'd2);

    // Illegal 00->11
    p0 = pulse_cnt;
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    tick(5);
    check("ill err_early", 32'(bus.err), 32'd0);
    tick(1);
    check("ill err", 32'(bus.err), 32'd1);
    check("ill step", 32'(bus.step), 32'd0);
    check("ill pos", 32'(bus.pos), 32'd0);
    check("ill dir", 32'(bus.dir), 32'd1);
    tick(4);
    // Illegal 11->00 accepted together with err_clr
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    tick(5);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("ill2 err_held", 32'(bus.err), 32'd1);
    check("ill2 step", 32'(bus.step), 32'd0);
    check("ill2 pos", 32'(bus.pos), 32'd0);
    tick(4);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("err_clr", 32'(bus.err), 32'd0);
    check("ill pulses", 32'(pulse_cnt - p0), 32'd0);

    // Count to 5, then clr collides with the next up step
    ab = 2'b00;
    epos = '0;
    for (int i = 0; i < 5; i++) begin
      ab = up(ab);
      epos = epos + 8'd1;
      move(ab, 1'b1, epos, $sformatf("pre%0d", i));
    end
    ab = up(ab);
    {bus.a_in, bus.b_in} = ab;
    tick(5);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    check("clr pos", 32'(bus.pos), 32'd0);
    check("clr step", 32'(bus.step), 32'd1);
    check("clr dir", 32'(bus.dir), 32'd1);
    tick(2);

    // Reset while an edge is in the filter
    ab = up(ab);
    {bus.a_in, bus.b_in} = ab;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid rst step", 32'(bus.step), 32'd0);
    check("mid rst dir", 32'(bus.dir), 32'd0);
    check("mid rst pos", 32'(bus.pos), 32'd0);
    check("mid rst err", 32'(bus.err), 32'd0);
    p0 = pulse_cnt;
    tick(12);
    check("rearm pulses", 32'(pulse_cnt - p0), 32'd0);
    check("rearm pos", 32'(bus.pos), 32'd0);
    check("rearm err", 32'(bus.err), 32'd0);
    ab = up(ab);
    move(ab, 1'b1, 8'd1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
